// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-cycle execute stage (IDLE/READ/EXEC/WB) driving an external combinational ALU.
// Optional divide/mod-by-zero trap enabled with `define ALU_SEQ_DIV0_TRAP_EN.
module alu_sequencer #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_operand1,
    output logic [7:0]  alu_operand2,
    input  logic [7:0]  alu_out,
    output logic        done,
    output logic [7:0]  done_data,
    output logic        zero,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_MOD = 4'h4;
    localparam logic [3:0] OP_LDI = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] instr_q;
    logic [7:0]  regs [NREGS];
    logic [7:0]  op1, op2, res;
    logic [3:0]  alu_op_q;
    logic        suppress;
    logic        div0;

    logic [3:0]  op_f;
    logic [2:0]  rd_f, rs1_f, rs2_f;
    logic [7:0]  imm_f;

    assign op_f  = instr_q[15:12];
    assign rd_f  = instr_q[11:9];
    assign rs1_f = instr_q[8:6];
    assign rs2_f = instr_q[5:3];
    assign imm_f = instr_q[7:0];

    assign instr_ready  = (state == S_IDLE);
    // op1/op2 only change at the end of READ, so the ALU inputs hold outside EXEC
    assign alu_op       = alu_op_q;
    assign alu_operand1 = op1;
    assign alu_operand2 = op2;
    assign dbg_data     = regs[dbg_addr];

`ifdef ALU_SEQ_DIV0_TRAP_EN
    logic err_q;

    assign div0 = ((op_f == OP_DIV) || (op_f == OP_MOD)) && (op2 == 8'h00);
    assign err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state == S_EXEC && div0)
            err_q <= 1'b1;
    end
`else
    assign div0 = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (instr_valid) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= '0;
            op1       <= '0;
            op2       <= '0;
            res       <= '0;
            alu_op_q  <= '0;
            suppress  <= 1'b0;
            done      <= 1'b0;
            done_data <= '0;
            zero      <= 1'b1;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid)
                        instr_q <= instr;
                end
                S_READ: begin
                    op1      <= regs[rs1_f];
                    op2      <= regs[rs2_f];
                    alu_op_q <= op_f;
                end
                S_EXEC: begin
                    if (op_f == OP_LDI) begin
                        res      <= imm_f;
                        suppress <= 1'b0;
                    end else if (div0) begin
                        res      <= 8'h00;
                        suppress <= 1'b1;
                    end else begin
                        res      <= alu_out;
                        suppress <= 1'b0;
                    end
                end
                S_WB: begin
                    // trapped results still report done, but never reach the register file
                    if (!suppress)
                        regs[rd_f] <= res;
                    done      <= 1'b1;
                    done_data <= res;
                    zero      <= (res == 8'h00);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute stage that sits directly upstream of the combinational `alu`. It does three things:
- accepts 16-bit register-to-register instructions over a valid/ready handshake;
- reads operands from an internal 8x8-bit register file and drives the ALU's `alu_op`/`alu_operand1`/`alu_operand2`;
- captures `alu_out` and writes it back to the register file.

It also provides a load-immediate path, a zero flag, a completion pulse and a debug read port.

## Interface
- `NREGS`, 8: register-file depth; fixed at 8 (3-bit register specifiers).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `instr_valid`  input  1  instruction present.
- `instr`  input  16  fields:
  - `op=[15:12]`, `rd=[11:9]`, `rs1=[8:6]`, `rs2=[5:3]`; `[2:0]` ignored.
  - For `op=4'hF` (LDI): `imm=[7:0]`.
- `instr_ready`  output  1  high only in IDLE.
- `alu_op`  output  4  to ALU.
- `alu_operand1`  output  8  to ALU.
- `alu_operand2`  output  8  to ALU.
- `alu_out`  input  8  from ALU (combinational).
- `done`  output  1  one-cycle pulse on writeback.
- `done_data`  output  8  value written (or suppressed result); held until next `done`.
- `zero`  output  1  `done_data == 0`; updated with `done`.
- `err`  output  1  sticky divide/mod-by-zero flag (see Configuration).
- `dbg_addr`  input  3  debug register index.
- `dbg_data`  output  8  combinational `regs[dbg_addr]`.

## Operation
- FSM states and transitions:
  - IDLE → READ on `instr_valid && instr_ready`; `instr` is latched.
  - READ → EXEC.
  - EXEC → WB.
  - WB → IDLE.
- READ: `op1 <= regs[rs1]`, `op2 <= regs[rs2]` into registered operand latches.
- EXEC: `alu_op`, `alu_operand1` and `alu_operand2` are driven from the latched op and operand registers; `res <= alu_out` at the end of EXEC.
  - For LDI: `res <= imm`; `alu_op` is still driven but `alu_out` is ignored.
- WB: `regs[rd] <= res`, `done_data <= res`, `zero <= (res == 0)`, `done` = 1 for that cycle.
- ALU outputs outside EXEC hold their last values; the ALU is combinational so this is harmless.
- Op codes 0–14 pass to the ALU unchanged; undefined codes write back whatever the ALU returns (0 by default).
- `rd` may equal `rs1`/`rs2`: operands are already captured in READ, so the old values are used.
- Arithmetic is 8-bit wraparound, as defined by the ALU; no carry or overflow output.
- `instr` changes while busy are ignored; no instruction buffering.

## Timing
- Accept edge = cycle 0.
- READ at cycle 1, EXEC at cycle 2, WB at cycle 3.
- Register update and `done` are visible after the cycle-3 edge.
- `instr_ready` returns high in cycle 4, so throughput is one instruction per 4 cycles.
- Back-to-back dependent instructions are safe: writeback completes before the next READ.
- `dbg_data` reflects a write in the cycle after WB.
- Reset (async, any state) clears:
  - state → IDLE
  - all `regs`, `op1`, `op2` and `res` → 0
  - `alu_op`/operands → 0
  - `done` → 0, `done_data` → 0, `zero` → 1, `err` → 0
  - `instr_ready` → 1 after release.
- Reset mid-instruction aborts it with no writeback.

## Configuration
- `ALU_SEQ_DIV0_TRAP_EN` defined:
  - Applies when op is 3 (DIV) or 4 (MOD) and `op2 == 0`.
  - In EXEC, `res <= 8'h00` and `err` is set (sticky until reset).
  - In WB, the register write is suppressed; `done` still pulses with `done_data = 0`.
- Undefined: no check; `alu_out` is written back as-is and `err` is tied 0.

## Test plan
- Reset, then `dbg_addr` sweep over 0–7 → every `dbg_data = 0`; `zero = 1`; `instr_ready = 1`.
- `LDI r1,200`; `LDI r2,100`; `ADD r3,r1,r2` → `done_data = 44`, r3 = 44; `done` pulses 3 cycles after each accept; `instr_ready` is low for 3 cycles after each accept.
- Using the r1/r2 values from the previous test: `SUB r4,r2,r1` → 156; `MUL r5,r1,r2` → 32; `AND r6,r1,r2` → 64.
- `LDI r7,0`; `DIV r0,r1,r7`:
  - with `ALU_SEQ_DIV0_TRAP_EN`: `err = 1`, r0 unchanged, `done_data = 0`, `zero = 1`;
  - without it: `err` stays 0.
- `LDI r1,5`; `SUB r1,r1,r1` → r1 = 0, `zero = 1`; holding `instr_valid` high continuously → exactly one accept per 4 cycles.
- Assert `rst_n` low during EXEC of `ADD r3,r1,r2` → no `done`, r3 = 0, state IDLE after release.
